// File: rtl/cam_forward_window.sv
// cam_forward_window: multi-entry forwarding window for the CAM lookup path.
// Keeps the last DEPTH write/delete operations that the table has not yet
// absorbed and patches a lookup result read from stale table state. Entry 0
// is the youngest operation, and the youngest matching entry decides the result.
module cam_forward_window #(
    parameter int DATA_WIDTH = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int DEPTH      = 3,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush_i,
    input  logic [KEY_WIDTH-1:0]  new_key_i,
    input  logic [DATA_WIDTH-1:0] new_data_i,
    input  logic                  new_valid_i,
    input  logic [KEY_WIDTH-1:0]  forward_key_i,
    input  logic [DATA_WIDTH-1:0] forward_data_i,
    input  logic                  forward_write_i,
    input  logic                  forward_del_i,
    output logic [DATA_WIDTH-1:0] corrected_data_o,
    output logic                  correct_valid_o,
    output logic                  fwd_hit_o,
    output logic [IDX_W-1:0]      fwd_index_o,
    output logic [OCC_W-1:0]      occupancy_o,
    output logic                  op_error_o
);

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_write;
    logic [KEY_WIDTH-1:0]  ent_key  [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];

    logic [DEPTH-1:0]      next_valid;
    logic [OCC_W-1:0]      next_occ;

    // Valid bits after the next enabled edge: shift, drop older entries on flush, load the new op.
    always_comb begin
        next_valid = '0;
        for (int i = 1; i < DEPTH; i++) begin
            next_valid[i] = flush_i ? 1'b0 : ent_valid[i-1];
        end
        next_valid[0] = forward_write_i ^ forward_del_i;
    end

    // Population count of the next valid vector, registered as occupancy.
    always_comb begin
        next_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            next_occ = next_occ + OCC_W'(next_valid[i]);
        end
    end

    // Window shift register plus occupancy and sticky illegal-operation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid   <= '0;
            ent_write   <= '0;
            occupancy_o <= '0;
            op_error_o  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_key[i]  <= '0;
                ent_data[i] <= '0;
            end
        end else if (clk_en) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                ent_key[i]   <= ent_key[i-1];
                ent_data[i]  <= ent_data[i-1];
                ent_write[i] <= ent_write[i-1];
            end
            ent_key[0]   <= forward_key_i;
            ent_data[0]  <= forward_data_i;
            ent_write[0] <= forward_write_i;
            ent_valid    <= next_valid;
            occupancy_o  <= next_occ;
            if (forward_write_i && forward_del_i) begin
                op_error_o <= 1'b1;
            end
        end
    end

    // Zero-latency lookup: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        corrected_data_o = new_data_i;
        correct_valid_o  = new_valid_i;
        fwd_hit_o        = 1'b0;
        fwd_index_o      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_key[i] == new_key_i)) begin
                fwd_hit_o   = 1'b1;
                fwd_index_o = IDX_W'(i);
                if (ent_write[i]) begin
                    corrected_data_o = ent_data[i];
                    correct_valid_o  = 1'b1;
                end else begin
                    corrected_data_o = new_data_i;
                    correct_valid_o  = 1'b0;
                end
            end
        end
    end

endmodule
